// File: rtl/sd_emmc_controller_sdma_burst.sv
// SDMA burst engine: moves eMMC data blocks between the card-side FIFOs and system memory
// over an AXI-style master, honouring block size, 4 KiB pages and the SDMA buffer boundary.
//
//   state      | meaning
//   IDLE       | waiting for start
//   ADDR       | sizing the next burst, presenting AW or AR until accepted
//   DATA       | W beats (card->mem) or R beats (mem->card)
//   RESP       | waiting for the write response
//   BLK_CHECK  | block accounting, completion and boundary decision
//   BND_WAIT   | paused at a buffer boundary until a new system address arrives
//   DONE       | transfer finished, waiting for the data line to complete

module sd_emmc_controller_sdma_burst #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BLKCNT_W  = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                dir,
    input  logic [11:0]         blk_size,
    input  logic [BLKCNT_W-1:0] blk_count,
    input  logic                blk_count_ena,
    input  logic [2:0]          buf_boundary,
    input  logic [ADDR_W-1:0]   init_sys_addr,
    input  logic                sys_addr_changed,
    input  logic                abort,
    input  logic [1:0]          int_clr,
    input  logic                xfer_compl,
    input  logic [9:0]          rd_fifo_count,
    output logic                rd_fifo_pop,
    input  logic [9:0]          wr_fifo_space,
    output logic                wr_fifo_push,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic                awvalid,
    input  logic                awready,
    output logic                wvalid,
    input  logic                wready,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic                arvalid,
    input  logic                arready,
    input  logic                rvalid,
    output logic                rready,
    input  logic                rlast,
    output logic [1:0]          dma_interrupts,
    output logic                busy,
    output logic [BLKCNT_W-1:0] blocks_done
);

    localparam int BYTES      = DATA_W / 8;
    localparam int LOG2_BYTES = $clog2(BYTES);
    localparam int WL_W       = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_BLK_CHECK,
        S_BND_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WL_W-1:0]     words_left_q, words_left_d;
    logic [WL_W-1:0]     words_per_blk_q, words_per_blk_d;
    logic [BLKCNT_W-1:0] blocks_done_q, blocks_done_d;
    logic [BLKCNT_W-1:0] blk_target_q, blk_target_d;
    logic                cnt_ena_q, cnt_ena_d;
    logic                dir_q, dir_d;
    logic [2:0]          boundary_q, boundary_d;
    logic [WL_W-1:0]     len_q, len_d;
    logic [WL_W-1:0]     beat_q, beat_d;
    logic [7:0]          axlen_q, axlen_d;
    logic                awvalid_q, awvalid_d;
    logic                arvalid_q, arvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                wlast_q, wlast_d;
    logic                bready_q, bready_d;
    logic                rready_q, rready_d;
    logic [1:0]          int_q, int_d;
    logic                abort_pend_q, abort_pend_d;
    logic                busy_q, busy_d;

    logic [WL_W-1:0]     page_bytes, page_words, burst_l;
    logic [ADDR_W-1:0]   addr_next, bnd_mask;
    logic [1:0]          int_set;
    logic                fifo_ok, aw_hs, ar_hs, w_hs, r_hs, b_hs, beat_last, stop_req;

    // The beat count alone defines the end of a read burst; rlast is advisory.
    logic unused_rlast;
    assign unused_rlast = rlast;

    // Clip each burst to the block remainder and to the current 4 KiB page; since every
    // buffer boundary is a multiple of 4 KiB this also keeps bursts inside the boundary.
    always_comb begin
        page_bytes = WL_W'(13'h1000) - {1'b0, addr_q[11:0]};
        page_words = page_bytes >> LOG2_BYTES;
        burst_l    = WL_W'(MAX_BURST);
        if (words_left_q < burst_l) burst_l = words_left_q;
        if (page_words < burst_l)   burst_l = page_words;
    end

    assign fifo_ok   = dir_q ? ({3'b000, rd_fifo_count} >= burst_l)
                             : ({3'b000, wr_fifo_space} >= burst_l);
    assign aw_hs     = awvalid_q & awready;
    assign ar_hs     = arvalid_q & arready;
    assign w_hs      = wvalid_q & wready;
    assign r_hs      = rready_q & rvalid;
    assign b_hs      = bready_q & bvalid;
    assign beat_last = (beat_q == len_q - WL_W'(1));
    assign addr_next = addr_q + (ADDR_W'(len_q) << LOG2_BYTES);
    assign bnd_mask  = (ADDR_W'(13'h1000) << boundary_q) - ADDR_W'(1);
    assign stop_req  = abort | abort_pend_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        words_left_d    = words_left_q;
        words_per_blk_d = words_per_blk_q;
        blocks_done_d   = blocks_done_q;
        blk_target_d    = blk_target_q;
        cnt_ena_d       = cnt_ena_q;
        dir_d           = dir_q;
        boundary_d      = boundary_q;
        len_d           = len_q;
        beat_d          = beat_q;
        axlen_d         = axlen_q;
        awvalid_d       = awvalid_q;
        arvalid_d       = arvalid_q;
        wvalid_d        = wvalid_q;
        wlast_d         = wlast_q;
        bready_d        = bready_q;
        rready_d        = rready_q;
        abort_pend_d    = abort_pend_q;
        int_set         = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    addr_d          = init_sys_addr;
                    words_per_blk_d = WL_W'(blk_size / 12'(BYTES));
                    words_left_d    = WL_W'(blk_size / 12'(BYTES));
                    blocks_done_d   = '0;
                    blk_target_d    = (blk_count == '0) ? BLKCNT_W'(1) : blk_count;
                    cnt_ena_d       = blk_count_ena;
                    dir_d           = dir;
                    boundary_d      = buf_boundary;
                    abort_pend_d    = 1'b0;
                    state_d         = S_ADDR;
                end
            end
            S_ADDR: begin
                if (aw_hs || ar_hs) begin
                    awvalid_d    = 1'b0;
                    arvalid_d    = 1'b0;
                    beat_d       = '0;
                    abort_pend_d = abort;
                    state_d      = S_DATA;
                    if (dir_q) begin
                        wvalid_d = 1'b1;
                        wlast_d  = (len_q == WL_W'(1));
                    end else begin
                        rready_d = 1'b1;
                    end
                end else if (abort) begin
                    awvalid_d = 1'b0;
                    arvalid_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (!awvalid_q && !arvalid_q && fifo_ok) begin
                    len_d     = burst_l;
                    axlen_d   = 8'(burst_l - WL_W'(1));
                    awvalid_d = dir_q;
                    arvalid_d = !dir_q;
                end
            end
            S_DATA: begin
                if (abort) abort_pend_d = 1'b1;
                if (dir_q) begin
                    if (w_hs) begin
                        beat_d = beat_q + WL_W'(1);
                        if (beat_last) begin
                            wvalid_d = 1'b0;
                            wlast_d  = 1'b0;
                            bready_d = 1'b1;
                            state_d  = S_RESP;
                        end else begin
                            wlast_d = (beat_q + WL_W'(2) == len_q);
                        end
                    end
                end else if (r_hs) begin
                    beat_d = beat_q + WL_W'(1);
                    if (beat_last) begin
                        rready_d     = 1'b0;
                        addr_d       = addr_next;
                        words_left_d = words_left_q - len_q;
                        state_d      = stop_req ? S_IDLE : S_BLK_CHECK;
                    end
                end
            end
            S_RESP: begin
                if (abort) abort_pend_d = 1'b1;
                if (b_hs) begin
                    bready_d     = 1'b0;
                    addr_d       = addr_next;
                    words_left_d = words_left_q - len_q;
                    state_d      = stop_req ? S_IDLE : S_BLK_CHECK;
                end
            end
            S_BLK_CHECK: begin
                if (stop_req) begin
                    state_d = S_IDLE;
                end else if (words_left_q != '0) begin
                    state_d = S_ADDR;
                end else begin
                    blocks_done_d = blocks_done_q + BLKCNT_W'(1);
                    words_left_d  = words_per_blk_q;
                    if (cnt_ena_q && (blocks_done_q + BLKCNT_W'(1) == blk_target_q)) begin
                        int_set[0] = 1'b1;
                        state_d    = S_DONE;
                    end else if ((addr_q & bnd_mask) == '0) begin
                        int_set[1] = 1'b1;
                        state_d    = S_BND_WAIT;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_BND_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (sys_addr_changed) begin
                    addr_d  = init_sys_addr;
                    state_d = S_ADDR;
                end
            end
            S_DONE: begin
                if (xfer_compl || !dir_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new event outranks a simultaneous clear of the same bit.
        int_d  = (int_q & ~int_clr) | int_set;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            words_left_q    <= '0;
            words_per_blk_q <= '0;
            blocks_done_q   <= '0;
            blk_target_q    <= '0;
            cnt_ena_q       <= 1'b0;
            dir_q           <= 1'b0;
            boundary_q      <= '0;
            len_q           <= '0;
            beat_q          <= '0;
            axlen_q         <= '0;
            awvalid_q       <= 1'b0;
            arvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            wlast_q         <= 1'b0;
            bready_q        <= 1'b0;
            rready_q        <= 1'b0;
            int_q           <= '0;
            abort_pend_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            words_left_q    <= words_left_d;
            words_per_blk_q <= words_per_blk_d;
            blocks_done_q   <= blocks_done_d;
            blk_target_q    <= blk_target_d;
            cnt_ena_q       <= cnt_ena_d;
            dir_q           <= dir_d;
            boundary_q      <= boundary_d;
            len_q           <= len_d;
            beat_q          <= beat_d;
            axlen_q         <= axlen_d;
            awvalid_q       <= awvalid_d;
            arvalid_q       <= arvalid_d;
            wvalid_q        <= wvalid_d;
            wlast_q         <= wlast_d;
            bready_q        <= bready_d;
            rready_q        <= rready_d;
            int_q           <= int_d;
            abort_pend_q    <= abort_pend_d;
            busy_q          <= busy_d;
        end
    end

    assign awaddr         = addr_q;
    assign araddr         = addr_q;
    assign awlen          = axlen_q;
    assign arlen          = axlen_q;
    assign awvalid        = awvalid_q;
    assign arvalid        = arvalid_q;
    assign wvalid         = wvalid_q;
    assign wlast          = wlast_q;
    assign bready         = bready_q;
    assign rready         = rready_q;
    assign rd_fifo_pop    = w_hs;
    assign wr_fifo_push   = r_hs;
    assign dma_interrupts = int_q;
    assign busy           = busy_q;
    assign blocks_done    = blocks_done_q;

endmodule

// File: tb/tb_sd_emmc_controller_sdma_burst.sv
// Directed bench for the SDMA burst engine: a reactive AXI slave/monitor plus one task per scenario.

module tb_sd_emmc_controller_sdma_burst;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, dir, blk_count_ena, sys_addr_changed, abort, xfer_compl;
    logic [11:0] blk_size;
    logic [15:0] blk_count;
    logic [2:0]  buf_boundary;
    logic [31:0] init_sys_addr;
    logic [1:0]  int_clr;
    logic [9:0]  rd_fifo_count, wr_fifo_space;
    logic        rd_fifo_pop, wr_fifo_push;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [1:0]  dma_interrupts;
    logic        busy;
    logic [15:0] blocks_done;

    int checks, failures;
    int aw_hold_req;
    int aw_cnt, ar_cnt, w_beats, wlast_cnt, wlast_err, b_cnt, r_beats;
    int pop_err, push_err, stab_err, hold_seen, aw_stall;
    int cur_len, beat_in, b_pend, r_left;
    logic        stall_prev;
    logic [31:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    logic [31:0] aw_addr_log[$];
    int          aw_len_log[$];
    logic [31:0] ar_addr_log[$];
    int          ar_len_log[$];

    always #5 clock = ~clock;

    sd_emmc_controller_sdma_burst #(
        .DATA_W(32), .ADDR_W(32), .BLKCNT_W(16), .MAX_BURST(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .dir(dir),
        .blk_size(blk_size), .blk_count(blk_count), .blk_count_ena(blk_count_ena),
        .buf_boundary(buf_boundary), .init_sys_addr(init_sys_addr),
        .sys_addr_changed(sys_addr_changed), .abort(abort), .int_clr(int_clr),
        .xfer_compl(xfer_compl), .rd_fifo_count(rd_fifo_count), .rd_fifo_pop(rd_fifo_pop),
        .wr_fifo_space(wr_fifo_space), .wr_fifo_push(wr_fifo_push),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .dma_interrupts(dma_interrupts), .busy(busy), .blocks_done(blocks_done)
    );

    // AXI slave and monitor: drives ready/response at the falling edge, samples 1 ns later.
    initial begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        aw_cnt = 0; ar_cnt = 0; w_beats = 0; wlast_cnt = 0; wlast_err = 0; b_cnt = 0;
        r_beats = 0; pop_err = 0; push_err = 0; stab_err = 0; hold_seen = 0; aw_stall = 0;
        cur_len = 0; beat_in = 0; b_pend = 0; r_left = 0; stall_prev = 0;
        prev_awaddr = 0; prev_awlen = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
                aw_cnt = 0; ar_cnt = 0; w_beats = 0; wlast_cnt = 0; wlast_err = 0; b_cnt = 0;
                r_beats = 0; pop_err = 0; push_err = 0; stab_err = 0; hold_seen = 0;
                aw_stall = 0; cur_len = 0; beat_in = 0; b_pend = 0; r_left = 0; stall_prev = 0;
                aw_addr_log.delete(); aw_len_log.delete();
                ar_addr_log.delete(); ar_len_log.delete();
            end else begin
                awready = (aw_stall >= aw_hold_req);
                wready  = 1;
                arready = 1;
                bvalid  = (b_pend > 0);
                rvalid  = (r_left > 0);
                rlast   = (r_left == 1);
                #1;
                if (awvalid && stall_prev && (awaddr !== prev_awaddr || awlen !== prev_awlen))
                    stab_err++;
                stall_prev  = awvalid && !awready;
                prev_awaddr = awaddr;
                prev_awlen  = awlen;
                if (awvalid && !awready) begin
                    aw_stall++;
                    hold_seen++;
                end
                if (rd_fifo_pop !== (wvalid && wready)) pop_err++;
                if (wr_fifo_push !== (rvalid && rready)) push_err++;
                if (awvalid && awready) begin
                    aw_cnt++;
                    aw_addr_log.push_back(awaddr);
                    aw_len_log.push_back(int'(awlen));
                    cur_len  = int'(awlen) + 1;
                    beat_in  = 0;
                    aw_stall = 0;
                end
                if (wvalid && wready) begin
                    w_beats++;
                    beat_in++;
                    if (wlast !== (beat_in == cur_len)) wlast_err++;
                    if (wlast) begin
                        wlast_cnt++;
                        b_pend++;
                    end
                end
                if (bvalid && bready) begin
                    b_cnt++;
                    b_pend--;
                end
                if (rvalid && rready) begin
                    r_beats++;
                    r_left--;
                end
                if (arvalid && arready) begin
                    ar_cnt++;
                    ar_addr_log.push_back(araddr);
                    ar_len_log.push_back(int'(arlen));
                    r_left = int'(arlen) + 1;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    task automatic reset_dut();
        reset = 1; start = 0; abort = 0; sys_addr_changed = 0; xfer_compl = 0;
        int_clr = 0; aw_hold_req = 0;
        cyc(3);
        reset = 0;
        cyc(1);
    endtask

    task automatic kick(input logic d, input int size, input int cnt, input logic ena,
                        input int bb, input logic [31:0] addr);
        dir = d; blk_size = 12'(size); blk_count = 16'(cnt); blk_count_ena = ena;
        buf_boundary = 3'(bb); init_sys_addr = addr;
        start = 1;
        cyc(1);
        start = 0;
    endtask

    task automatic pulse_xfer_compl();
        xfer_compl = 1;
        cyc(1);
        xfer_compl = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (dma_interrupts !== 2'b00) begin failures++; $display("FAIL reset_int got=%b exp=00", dma_interrupts); end
        checks++; if (blocks_done !== 16'd0) begin failures++; $display("FAIL reset_blocks got=%0d exp=0", blocks_done); end
        checks++; if ({awvalid, arvalid, wvalid, bready, rready} !== 5'b0) begin
            failures++; $display("FAIL reset_axi got=%b exp=00000", {awvalid, arvalid, wvalid, bready, rready}); end
        checks++; if (awaddr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", awaddr); end
        rd_fifo_count = 10'd1023; wr_fifo_space = 10'd0;
        kick(1'b1, 512, 2, 1'b1, 0, 32'h1000_0000);
        cyc(8);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midburst_busy got=%0b exp=1", busy); end
        reset = 1;
        cyc(1);
        checks++; if (busy !== 1'b0 || wvalid !== 1'b0 || awvalid !== 1'b0) begin
            failures++; $display("FAIL midburst_reset busy=%0b wvalid=%0b awvalid=%0b exp=0", busy, wvalid, awvalid); end
        checks++; if (awaddr !== 32'h0) begin failures++; $display("FAIL midburst_reset_addr got=%h exp=0", awaddr); end
        reset = 0;
    endtask

    task automatic test_c2m_512();
        bit ok;
        int bad;
        reset_dut();
        rd_fifo_count = 10'd1023;
        kick(1'b1, 512, 2, 1'b1, 0, 32'h1000_0000);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin cyc(1); ok = dma_interrupts[0]; end
        checks++; if (!ok) begin failures++; $display("FAIL c2m_timeout int0 got=0 exp=1"); end
        checks++; if (aw_cnt != 16) begin failures++; $display("FAIL c2m_aw_cnt got=%0d exp=16", aw_cnt); end
        bad = 0;
        for (int i = 0; i < aw_addr_log.size(); i++)
            if (aw_addr_log[i] !== 32'h1000_0000 + 32'(i) * 32'h40 || aw_len_log[i] != 15) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL c2m_aw_pattern bad_bursts=%0d exp=0", bad); end
        checks++; if (w_beats != 256) begin failures++; $display("FAIL c2m_w_beats got=%0d exp=256", w_beats); end
        checks++; if (wlast_cnt != 16 || wlast_err != 0) begin
            failures++; $display("FAIL c2m_wlast count=%0d err=%0d exp=16/0", wlast_cnt, wlast_err); end
        checks++; if (dma_interrupts !== 2'b01) begin failures++; $display("FAIL c2m_int got=%b exp=01", dma_interrupts); end
        checks++; if (blocks_done !== 16'd2) begin failures++; $display("FAIL c2m_blocks got=%0d exp=2", blocks_done); end
        checks++; if (pop_err != 0) begin failures++; $display("FAIL c2m_pop err=%0d exp=0", pop_err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL c2m_done_wait busy=%0b exp=1", busy); end
        pulse_xfer_compl();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL c2m_idle busy=%0b exp=0", busy); end
    endtask

    task automatic test_blk_520();
        bit ok;
        reset_dut();
        rd_fifo_count = 10'd1023;
        kick(1'b1, 520, 2, 1'b1, 0, 32'h1000_0000);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin cyc(1); ok = dma_interrupts[0]; end
        checks++; if (!ok) begin failures++; $display("FAIL b520_timeout int0 got=0 exp=1"); end
        checks++; if (aw_cnt != 18) begin failures++; $display("FAIL b520_aw_cnt got=%0d exp=18", aw_cnt); end
        checks++; if (aw_addr_log[9] !== 32'h1000_0208) begin
            failures++; $display("FAIL b520_blk2_addr got=%h exp=10000208", aw_addr_log[9]); end
        checks++; if (aw_len_log[8] != 1 || aw_len_log[17] != 1 || aw_len_log[7] != 15) begin
            failures++; $display("FAIL b520_lens got=%0d/%0d/%0d exp=15/1/1", aw_len_log[7], aw_len_log[8], aw_len_log[17]); end
        checks++; if (w_beats != 260 || wlast_err != 0) begin
            failures++; $display("FAIL b520_beats got=%0d err=%0d exp=260/0", w_beats, wlast_err); end
        checks++; if (awaddr !== 32'h1000_0410) begin failures++; $display("FAIL b520_final_addr got=%h exp=10000410", awaddr); end
        pulse_xfer_compl();
    endtask

    task automatic test_boundary();
        bit ok;
        reset_dut();
        rd_fifo_count = 10'd1023;
        kick(1'b1, 512, 8, 1'b1, 0, 32'h0000_0E00);
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin cyc(1); ok = dma_interrupts[1]; end
        checks++; if (!ok) begin failures++; $display("FAIL bnd_timeout int1 got=0 exp=1"); end
        checks++; if (dma_interrupts !== 2'b10) begin failures++; $display("FAIL bnd_int got=%b exp=10", dma_interrupts); end
        checks++; if (blocks_done !== 16'd1 || awaddr !== 32'h0000_1000) begin
            failures++; $display("FAIL bnd_pause blocks=%0d addr=%h exp=1/00001000", blocks_done, awaddr); end
        cyc(5);
        checks++; if (aw_cnt != 8 || awvalid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL bnd_hold aw_cnt=%0d awvalid=%0b busy=%0b exp=8/0/1", aw_cnt, awvalid, busy); end
        init_sys_addr = 32'h2000_0000;
        sys_addr_changed = 1;
        cyc(1);
        sys_addr_changed = 0;
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin cyc(1); ok = dma_interrupts[0]; end
        checks++; if (!ok) begin failures++; $display("FAIL bnd_resume_timeout int0 got=0 exp=1"); end
        checks++; if (aw_cnt != 64 || aw_addr_log[8] !== 32'h2000_0000) begin
            failures++; $display("FAIL bnd_resume aw_cnt=%0d first=%h exp=64/20000000", aw_cnt, aw_addr_log[8]); end
        checks++; if (awaddr !== 32'h2000_0E00 || blocks_done !== 16'd8) begin
            failures++; $display("FAIL bnd_final addr=%h blocks=%0d exp=20000e00/8", awaddr, blocks_done); end
        checks++; if (dma_interrupts !== 2'b11) begin failures++; $display("FAIL bnd_final_int got=%b exp=11", dma_interrupts); end
        pulse_xfer_compl();
    endtask

    task automatic test_m2c_space();
        bit ok;
        reset_dut();
        rd_fifo_count = 10'd1023;
        wr_fifo_space = 10'd5;
        kick(1'b0, 64, 0, 1'b1, 0, 32'h3000_0000);
        cyc(10);
        kick(1'b1, 512, 4, 1'b1, 0, 32'h7000_0000);
        dir = 1'b0;
        cyc(10);
        checks++; if (ar_cnt != 0 || arvalid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL m2c_holdoff ar_cnt=%0d arvalid=%0b busy=%0b exp=0/0/1", ar_cnt, arvalid, busy); end
        wr_fifo_space = 10'd16;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin cyc(1); ok = dma_interrupts[0]; end
        checks++; if (!ok) begin failures++; $display("FAIL m2c_timeout int0 got=0 exp=1"); end
        checks++; if (ar_cnt != 1 || ar_len_log[0] != 15 || ar_addr_log[0] !== 32'h3000_0000) begin
            failures++; $display("FAIL m2c_ar cnt=%0d len=%0d addr=%h exp=1/15/30000000", ar_cnt, ar_len_log[0], ar_addr_log[0]); end
        checks++; if (r_beats != 16 || push_err != 0) begin
            failures++; $display("FAIL m2c_push beats=%0d err=%0d exp=16/0", r_beats, push_err); end
        checks++; if (aw_cnt != 0 || blocks_done !== 16'd1) begin
            failures++; $display("FAIL m2c_misc aw_cnt=%0d blocks=%0d exp=0/1", aw_cnt, blocks_done); end
        cyc(1);
        checks++; if (busy !== 1'b0 || araddr !== 32'h3000_0040) begin
            failures++; $display("FAIL m2c_end busy=%0b addr=%h exp=0/30000040", busy, araddr); end
    endtask

    task automatic test_abort();
        bit ok;
        reset_dut();
        rd_fifo_count = 10'd1023;
        aw_hold_req = 10;
        kick(1'b1, 512, 4, 1'b1, 0, 32'h4000_0000);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin cyc(1); ok = (aw_cnt == 1); end
        checks++; if (!ok) begin failures++; $display("FAIL abort_aw_timeout aw_cnt=%0d exp=1", aw_cnt); end
        checks++; if (hold_seen != 10 || stab_err != 0) begin
            failures++; $display("FAIL abort_aw_stable held=%0d unstable=%0d exp=10/0", hold_seen, stab_err); end
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin cyc(1); ok = (w_beats >= 4); end
        abort = 1;
        cyc(1);
        abort = 0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin cyc(1); ok = !busy; end
        checks++; if (!ok) begin failures++; $display("FAIL abort_idle_timeout busy=1 exp=0"); end
        checks++; if (w_beats != 16 || wlast_cnt != 1 || b_cnt != 1 || aw_cnt != 1) begin
            failures++; $display("FAIL abort_complete w=%0d last=%0d b=%0d aw=%0d exp=16/1/1/1", w_beats, wlast_cnt, b_cnt, aw_cnt); end
        checks++; if (dma_interrupts !== 2'b00 || blocks_done !== 16'd0) begin
            failures++; $display("FAIL abort_int int=%b blocks=%0d exp=00/0", dma_interrupts, blocks_done); end
        aw_hold_req = 0;
    endtask

    task automatic test_int_clr();
        bit ok;
        reset_dut();
        rd_fifo_count = 10'd1023;
        int_clr = 2'b01;
        kick(1'b1, 4, 1, 1'b1, 0, 32'h5000_0000);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin cyc(1); ok = dma_interrupts[0]; end
        checks++; if (!ok) begin failures++; $display("FAIL intclr_set_wins got=0 exp=1"); end
        cyc(1);
        checks++; if (dma_interrupts !== 2'b00) begin failures++; $display("FAIL intclr_clear got=%b exp=00", dma_interrupts); end
        checks++; if (busy !== 1'b1 || w_beats != 1) begin
            failures++; $display("FAIL intclr_state busy=%0b beats=%0d exp=1/1", busy, w_beats); end
        int_clr = 2'b00;
        pulse_xfer_compl();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL intclr_idle busy=%0b exp=0", busy); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1; start = 0; dir = 0; blk_size = 0; blk_count = 0; blk_count_ena = 0;
        buf_boundary = 0; init_sys_addr = 0; sys_addr_changed = 0; abort = 0; int_clr = 0;
        xfer_compl = 0; rd_fifo_count = 0; wr_fifo_space = 0; aw_hold_req = 0;
        test_reset();
        test_c2m_512();
        test_blk_520();
        test_boundary();
        test_m2c_space();
        test_abort();
        test_int_clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
